// File: rtl/ms_bus_arbiter_if.sv
// Shared master/slave register-write bus: address, data and the slave's ready.
interface ms_bus_arbiter_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              sready;

    modport master (output addr, output data, input sready);
    modport slave  (input addr, input data, output sready);
endinterface

// File: rtl/ms_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one register-write bus among NREQ
// requesters. Each transfer runs address phase, then data phase (held until
// sready or stall timeout), then a one-cycle completion pulse.
module ms_bus_arbiter #(
    parameter int NREQ      = 4,
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 8,
    parameter int MAX_STALL = 8,
    localparam int OW       = $clog2(NREQ),
    localparam int SW       = $clog2(MAX_STALL + 1)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          gnt,
    output logic                     err,
    output logic                     busy,
    output logic [OW-1:0]            owner,
    ms_bus_arbiter_if.master         bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [OW-1:0]     rr_q, rr_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [DATA_W-1:0] ldata_q, ldata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SW-1:0]     stall_q, stall_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic              pick_vld;
    logic [OW-1:0]     pick_idx;
    logic [SW-1:0]     stall_inc;

    // Round-robin pick: scan from the farthest offset down so the first set
    // bit at or after the pointer is the one left standing.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_q) + k) % NREQ]) begin
                pick_vld = 1'b1;
                pick_idx = OW'((int'(rr_q) + k) % NREQ);
            end
        end
    end

    assign stall_inc = stall_q + 1'b1;

    // Next-state and registered-output decode; gnt/err are computed one
    // cycle early so they are visible exactly during DONE.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        ldata_d = ldata_q;
        addr_d  = addr_q;
        data_d  = data_q;
        stall_d = stall_q;
        gnt_d   = '0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    // Payload sampled only here; the address goes straight
                    // onto the bus so ADDR shows it while data stays old.
                    owner_d = pick_idx;
                    addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
                    ldata_d = req_data[pick_idx*DATA_W +: DATA_W];
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                data_d  = ldata_q;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (bus.sready) begin
                    gnt_d[owner_q] = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    stall_d = stall_inc;
                    if (stall_inc == SW'(MAX_STALL)) begin
                        gnt_d[owner_q] = 1'b1;
                        err_d          = 1'b1;
                        state_d        = S_DONE;
                    end
                end
            end
            S_DONE: begin
                rr_d    = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                stall_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any transfer without a gnt.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            ldata_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            stall_q <= '0;
            gnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            ldata_q <= ldata_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            stall_q <= stall_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign owner    = owner_q;
    assign bus.addr = addr_q;
    assign bus.data = data_q;

endmodule

// File: tb/tb_ms_bus_arbiter.sv
// Bench for ms_bus_arbiter: transfer-level model compared every cycle, a
// 4-register slave with programmable ready delay, and directed scenarios.
module tb_ms_bus_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 2;
    localparam int DW   = 8;
    localparam int MS   = 8;

    logic              clk  = 1'b0;
    logic              rstn = 1'b0;
    logic [NREQ-1:0]   req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic              err, busy;
    logic [1:0]        owner;

    always #5 clk = ~clk;

    ms_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ms_bus_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .MAX_STALL(MS)) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .err(err), .busy(busy), .owner(owner), .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slave: four registers rewritten every cycle from addr/data; sready goes
    // high once data has been stable for lowcyc cycles (lowcyc=0: always ready).
    logic [DW-1:0] sreg [4];
    logic [DW-1:0] dprev;
    int since;
    int lowcyc;
    int eff;
    always_comb begin
        eff        = (bus.data != dprev) ? 0 : since;
        bus.sready = (eff >= lowcyc);
    end
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dprev <= '0;
            since <= 0;
            for (int i = 0; i < 4; i++) sreg[i] <= '0;
        end else begin
            sreg[bus.addr] <= bus.data;
            dprev          <= bus.data;
            since          <= (bus.data != dprev) ? 1 : ((since < 1000) ? since + 1 : since);
        end
    end

    // Inputs as seen mid-cycle; the model consumes them at the next edge.
    logic [NREQ-1:0]    req_c = '0;
    logic [NREQ*AW-1:0] ra_c  = '0;
    logic [NREQ*DW-1:0] rd_c  = '0;
    logic               srdy_c = 1'b0;

    // Transfer-level model: a transfer's age counts edges since it was won.
    bit            m_busy  = 1'b0;
    int            m_age   = 0;
    int            m_stall = 0;
    int            m_rr    = 0;
    int            e_owner = 0;
    logic [DW-1:0] m_D     = '0;
    logic [AW-1:0] e_addr  = '0;
    logic [DW-1:0] e_data  = '0;
    logic [NREQ-1:0] e_gnt = '0;
    logic          e_err   = 1'b0;

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            m_busy = 0; m_age = 0; m_stall = 0; m_rr = 0; e_owner = 0;
            m_D = '0; e_addr = '0; e_data = '0; e_gnt = '0; e_err = 1'b0;
        end else begin
            e_gnt = '0;
            e_err = 1'b0;
            if (!m_busy) begin
                if (req_c != '0) begin
                    int w;
                    bit found;
                    w = 0;
                    found = 0;
                    for (int k = 0; k < NREQ; k++)
                        if (!found && req_c[(m_rr + k) % NREQ]) begin
                            w = (m_rr + k) % NREQ;
                            found = 1;
                        end
                    e_owner = w;
                    e_addr  = ra_c[w*AW +: AW];
                    m_D     = rd_c[w*DW +: DW];
                    m_busy  = 1;
                    m_age   = 1;
                end
            end else if (m_age == 1) begin
                e_data  = m_D;
                m_age   = 2;
                m_stall = 0;
            end else if (m_age == 2) begin
                if (srdy_c) begin
                    e_gnt[e_owner] = 1'b1;
                    m_age = 3;
                end else begin
                    m_stall++;
                    if (m_stall == MS) begin
                        e_gnt[e_owner] = 1'b1;
                        e_err = 1'b1;
                        m_age = 3;
                    end
                end
            end else begin
                m_busy = 0;
                m_rr   = (e_owner + 1) % NREQ;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge clk);
        req_c  = req;
        ra_c   = req_addr;
        rd_c   = req_data;
        srdy_c = bus.sready;
        chk("cmp_addr",  32'(bus.addr), 32'(e_addr));
        chk("cmp_data",  32'(bus.data), 32'(e_data));
        chk("cmp_gnt",   32'(gnt),      32'(e_gnt));
        chk("cmp_err",   32'(err),      32'(e_err));
        chk("cmp_busy",  32'(busy),     32'(m_busy));
        chk("cmp_owner", 32'(owner),    32'(e_owner));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until a gnt shows up (bounded); n = edges taken.
    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == '0 && n < 60);
        if (gnt == '0) chk("gnt_timeout", 32'(n), 32'(0));
    endtask

    task automatic set_pl(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    int lat;
    logic [DW-1:0] tmp;

    initial begin
        req = '0; req_addr = '0; req_data = '0; lowcyc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr",  32'(bus.addr), 32'(0));
        chk("rst_data",  32'(bus.data), 32'(0));
        chk("rst_gnt",   32'(gnt),      32'(0));
        chk("rst_busy",  32'(busy),     32'(0));
        chk("rst_owner", 32'(owner),    32'(0));
        rstn = 1'b1;
        tick();

        // Single write: requester 0, addr 2, data 5A.
        set_pl(0, 2'd2, 8'h5A);
        req[0] = 1'b1;
        tick();
        chk("sw_addr_ph_addr", 32'(bus.addr), 32'(2));
        chk("sw_addr_ph_data", 32'(bus.data), 32'(0));
        set_pl(0, 2'd1, 8'hFF);  // must be ignored for this transfer
        tick();
        chk("sw_data_ph", 32'(bus.data), 32'h5A);
        chk("sw_no_gnt_yet", 32'(gnt), 32'(0));
        tick();
        chk("sw_gnt", 32'(gnt), 32'b0001);
        chk("sw_err", 32'(err), 32'(0));
        req[0] = 1'b0;
        chk("sw_reg_c", 32'(sreg[2]), 32'h5A);
        tick();

        // One stall cycle from the slave on requester 1.
        lowcyc = 1;
        set_pl(1, 2'd1, 8'h03);
        req[1] = 1'b1;
        wait_gnt(lat);
        chk("stall_lat", 32'(lat), 32'(4));
        chk("stall_gnt", 32'(gnt), 32'b0010);
        chk("stall_err", 32'(err), 32'(0));
        chk("stall_reg_b", 32'(sreg[1]), 32'h03);
        req[1] = 1'b0;
        lowcyc = 0;

        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        // Round robin with all four requesting.
        for (int i = 0; i < NREQ; i++) set_pl(i, AW'(i), 8'(8'h20 + i));
        req = 4'b1111;
        for (int k = 0; k < NREQ; k++) begin
            wait_gnt(lat);
            chk("rr_spacing", 32'(lat), (k == 0) ? 32'(3) : 32'(4));
            chk("rr_gnt", 32'(gnt), 32'(1 << k));
            tmp = 8'(8'h20 + k);
            chk("rr_reg", 32'(sreg[k]), 32'(tmp));
            req[k] = 1'b0;
        end
        tick();

        // Fairness wrap: after 3 was served, 0 goes before 3.
        set_pl(0, 2'd0, 8'h31);
        set_pl(3, 2'd3, 8'h43);
        req = 4'b1001;
        wait_gnt(lat);
        chk("wrap_lat0", 32'(lat), 32'(3));
        chk("wrap_gnt0", 32'(gnt), 32'b0001);
        req[0] = 1'b0;
        wait_gnt(lat);
        chk("wrap_lat3", 32'(lat), 32'(4));
        chk("wrap_gnt3", 32'(gnt), 32'b1000);
        chk("wrap_reg3", 32'(sreg[3]), 32'h43);
        req[3] = 1'b0;
        tick();

        // Stall timeout: slave never ready.
        lowcyc = 255;
        set_pl(2, 2'd2, 8'h77);
        req[2] = 1'b1;
        wait_gnt(lat);
        chk("to_lat", 32'(lat), 32'(2 + MS));
        chk("to_gnt", 32'(gnt), 32'b0100);
        chk("to_err", 32'(err), 32'(1));
        req[2] = 1'b0;
        lowcyc = 0;
        tick();
        set_pl(1, 2'd1, 8'h55);
        req[1] = 1'b1;
        wait_gnt(lat);
        chk("post_to_lat", 32'(lat), 32'(3));
        chk("post_to_gnt", 32'(gnt), 32'b0010);
        chk("post_to_err", 32'(err), 32'(0));
        chk("post_to_reg", 32'(sreg[1]), 32'h55);
        req[1] = 1'b0;
        tick();

        // Async reset in the data phase of a stalled transfer.
        lowcyc = 255;
        set_pl(2, 2'd2, 8'h66);
        req[2] = 1'b1;
        repeat (4) tick();
        req[1] = 1'b1;
        chk("ar_pre_busy", 32'(busy), 32'(1));
        rstn = 1'b0;
        #1;
        chk("ar_addr", 32'(bus.addr), 32'(0));
        chk("ar_data", 32'(bus.data), 32'(0));
        chk("ar_busy", 32'(busy),     32'(0));
        chk("ar_gnt",  32'(gnt),      32'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        lowcyc = 0;
        wait_gnt(lat);
        chk("ar_first_lat",   32'(lat),   32'(3));
        chk("ar_first_gnt",   32'(gnt),   32'b0010);
        chk("ar_first_owner", 32'(owner), 32'(1));
        req[1] = 1'b0;
        wait_gnt(lat);
        chk("ar_second_gnt", 32'(gnt), 32'b0100);
        req[2] = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
